// File: rtl/fwrisc_csr_pkg.sv
// Shared types and the CSR-number to regfile-slot mapping for the CSR sequencer.
// CSRs live in the upper half of the 64-entry regfile, above the 32 GPRs.
package fwrisc_csr_pkg;

  typedef enum logic [1:0] {
    OP_RSVD = 2'b00,
    OP_RW   = 2'b01,
    OP_RS   = 2'b10,
    OP_RC   = 2'b11
  } csr_op_e;

  typedef enum logic [2:0] {
    IDLE,
    READ,
    CALC,
    WCSR,
    WRD,
    RESP
  } csr_state_e;

  localparam logic [11:0] CSR_MSTATUS   = 12'h300;
  localparam logic [11:0] CSR_MISA      = 12'h301;
  localparam logic [11:0] CSR_MIE       = 12'h304;
  localparam logic [11:0] CSR_MTVEC     = 12'h305;
  localparam logic [11:0] CSR_MSCRATCH  = 12'h340;
  localparam logic [11:0] CSR_MEPC      = 12'h341;
  localparam logic [11:0] CSR_MCAUSE    = 12'h342;
  localparam logic [11:0] CSR_MTVAL     = 12'h343;
  localparam logic [11:0] CSR_MIP       = 12'h344;
  localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
  localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
  localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
  localparam logic [11:0] CSR_MINSTRETH = 12'hB82;
  localparam logic [11:0] CSR_MVENDORID = 12'hF11;
  localparam logic [11:0] CSR_MARCHID   = 12'hF12;
  localparam logic [11:0] CSR_MIMPID    = 12'hF13;
  localparam logic [11:0] CSR_MHARTID   = 12'hF14;

  typedef struct packed {
    logic       valid;
    logic [5:0] addr;
  } csr_map_t;

  function automatic csr_map_t csr_map(input logic [11:0] csr, input logic enable_counters);
    csr_map_t m;
    m.valid = 1'b1;
    m.addr  = 6'h00;
    case (csr)
      CSR_MSTATUS:   m.addr = 6'h20;
      CSR_MISA:      m.addr = 6'h21;
      CSR_MIE:       m.addr = 6'h22;
      CSR_MTVEC:     m.addr = 6'h23;
      CSR_MSCRATCH:  m.addr = 6'h24;
      CSR_MEPC:      m.addr = 6'h25;
      CSR_MCAUSE:    m.addr = 6'h26;
      CSR_MTVAL:     m.addr = 6'h27;
      CSR_MIP:       m.addr = 6'h28;
      // Counters vanish from the map entirely when the build omits them
      CSR_MCYCLE:    begin m.addr = 6'h29; m.valid = enable_counters; end
      CSR_MCYCLEH:   begin m.addr = 6'h2A; m.valid = enable_counters; end
      CSR_MINSTRET:  begin m.addr = 6'h2B; m.valid = enable_counters; end
      CSR_MINSTRETH: begin m.addr = 6'h2C; m.valid = enable_counters; end
      CSR_MVENDORID: m.addr = 6'h2D;
      CSR_MARCHID:   m.addr = 6'h2E;
      CSR_MIMPID:    m.addr = 6'h2F;
      CSR_MHARTID:   m.addr = 6'h30;
      default:       m.valid = 1'b0;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/fwrisc_csr_alu.sv
// Combinational read-modify-write value for CSRRW/CSRRS/CSRRC.
import fwrisc_csr_pkg::*;

module fwrisc_csr_alu (
  input  csr_op_e     op,
  input  logic [31:0] old_val,
  input  logic [31:0] src,
  output logic [31:0] result
);

  always_comb begin
    result = 32'h0;
    case (op)
      OP_RW:   result = src;
      OP_RS:   result = old_val | src;
      OP_RC:   result = old_val & ~src;
      default: result = 32'h0;
    endcase
  end

endmodule

// File: rtl/fwrisc_csr_seq.sv
// Multi-cycle CSR instruction sequencer sharing the GPR regfile port:
// read old CSR value, write new CSR value, then write old value to rd.
import fwrisc_csr_pkg::*;

module fwrisc_csr_seq #(
  parameter int ENABLE_COUNTERS = 1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  req_op,
  input  logic [11:0] req_csr,
  input  logic [31:0] req_src,
  input  logic [4:0]  req_src_idx,
  input  logic [4:0]  req_rd,
  output logic [5:0]  rb_raddr,
  input  logic [31:0] rb_rdata,
  output logic [5:0]  rd_waddr,
  output logic [31:0] rd_wdata,
  output logic        rd_wen,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic        resp_illegal
);

  csr_state_e  state, state_nxt;
  csr_map_t    req_map;
  logic        req_writes, req_illegal;

  csr_op_e     op_q;
  logic [5:0]  addr_q;
  logic [31:0] src_q;
  logic [4:0]  rd_q;
  logic        writes_q, illegal_q;
  logic [31:0] old_q, new_q;
  logic [31:0] alu_result;

  assign req_map     = csr_map(req_csr, ENABLE_COUNTERS != 0);
  assign req_writes  = (req_op == OP_RW) || (req_src_idx != 5'd0);
  assign req_illegal = (req_op == OP_RSVD) || !req_map.valid ||
                       ((req_csr[11:10] == 2'b11) && req_writes);

  fwrisc_csr_alu u_alu (
    .op      (op_q),
    .old_val (rb_rdata),
    .src     (src_q),
    .result  (alu_result)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      op_q      <= OP_RSVD;
      addr_q    <= 6'h0;
      src_q     <= 32'h0;
      rd_q      <= 5'h0;
      writes_q  <= 1'b0;
      illegal_q <= 1'b0;
      old_q     <= 32'h0;
      new_q     <= 32'h0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && req_valid) begin
        op_q      <= csr_op_e'(req_op);
        addr_q    <= req_map.addr;
        src_q     <= req_src;
        rd_q      <= req_rd;
        writes_q  <= req_writes;
        illegal_q <= req_illegal;
      end
      if (state == CALC) begin
        old_q <= rb_rdata;
        new_q <= alu_result;
      end
    end
  end

  // Each write state owns the single regfile write port for exactly one cycle
  always_comb begin
    state_nxt    = state;
    req_ready    = 1'b0;
    rb_raddr     = 6'h0;
    rd_waddr     = 6'h0;
    rd_wdata     = 32'h0;
    rd_wen       = 1'b0;
    resp_valid   = 1'b0;
    resp_illegal = 1'b0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_nxt = req_illegal ? RESP : READ;
      end
      READ: begin
        rb_raddr  = addr_q;
        state_nxt = CALC;
      end
      CALC: begin
        if (writes_q)          state_nxt = WCSR;
        else if (rd_q != 5'd0) state_nxt = WRD;
        else                   state_nxt = RESP;
      end
      WCSR: begin
        rd_wen    = 1'b1;
        rd_waddr  = addr_q;
        rd_wdata  = new_q;
        state_nxt = (rd_q != 5'd0) ? WRD : RESP;
      end
      WRD: begin
        rd_wen    = 1'b1;
        rd_waddr  = {1'b0, rd_q};
        rd_wdata  = old_q;
        state_nxt = RESP;
      end
      RESP: begin
        resp_valid   = 1'b1;
        resp_illegal = illegal_q;
        if (resp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule
